// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding for the truth table checker
package tt_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != '1)
            q <= q + W'(1);
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector and compares the function under test with TABLE
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                  N_IN  = 3,
    parameter logic [2**N_IN-1:0]  TABLE = 8'b01100001,
    parameter int                  ERR_W = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_z,
    output logic [N_IN-1:0]  x,
    output logic             z_t,
    output logic             d_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_x,
    output logic             first_err_vld
);
    state_t state, nxt;
    logic go, last, mis;
    assign z_t  = TABLE[x];
    assign last = x == '1;
    assign go   = start && state != RUN;
    assign mis  = state == RUN && dut_z != z_t;
    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    always_comb begin
        nxt  = go ? RUN : (state == RUN && last) ? DONE : state;
        busy = state == RUN;
        done = state == DONE;
        pass = state == DONE && err_count == '0;
    end
    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            x             <= '0;
            d_q           <= 1'b0;
            first_err_x   <= '0;
            first_err_vld <= 1'b0;
        end else if (go) begin
            x             <= '0;
            d_q           <= 1'b0;
            first_err_vld <= 1'b0;
        end else if (state == RUN) begin
            d_q <= dut_z;
            if (!last)
                x <= x + N_IN'(1);
            if (mis && !first_err_vld) begin
                first_err_x   <= x;
                first_err_vld <= 1'b1;
            end
        end
    sat_counter #(.W(ERR_W)) u_cnt (
        .clk  (clock),
        .rst_n(rst_n),
        .clr  (go),
        .inc  (mis),
        .q    (err_count)
    );
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: random error masks against two checker configurations, checked by a sweep model
module tb_truth_table_checker;
    localparam logic [7:0]  TA  = 8'b01100001;
    localparam logic [15:0] TBV = 16'h8001;
    logic clk, rst_n, start_a, start_b, sel;
    logic [7:0]  mask_a;
    logic [15:0] mask_b;
    logic [2:0] xa, fxa;
    logic [3:0] xb, fxb, erra;
    logic [1:0] errb;
    logic za, zb, zta, ztb, dqa, dqb, busya, busyb, donea, doneb, passa, passb, fva, fvb;
    int total = 0;
    int bad = 0;
    assign za = TA[xa] ^ mask_a[xa];
    assign zb = TBV[xb] ^ mask_b[xb];
    truth_table_checker u_a (
        .clock(clk), .rst_n(rst_n), .start(start_a), .dut_z(za), .x(xa), .z_t(zta), .d_q(dqa),
        .busy(busya), .done(donea), .pass(passa), .err_count(erra), .first_err_x(fxa), .first_err_vld(fva)
    );
    truth_table_checker #(.N_IN(4), .TABLE(16'h8001), .ERR_W(2)) u_b (
        .clock(clk), .rst_n(rst_n), .start(start_b), .dut_z(zb), .x(xb), .z_t(ztb), .d_q(dqb),
        .busy(busyb), .done(doneb), .pass(passb), .err_count(errb), .first_err_x(fxb), .first_err_vld(fvb)
    );
    wire [3:0] ox   = sel ? xb : {1'b0, xa};
    wire [3:0] ofx  = sel ? fxb : {1'b0, fxa};
    wire [3:0] oerr = sel ? {2'b0, errb} : erra;
    wire ozt   = sel ? ztb : zta;
    wire odq   = sel ? dqb : dqa;
    wire obusy = sel ? busyb : busya;
    wire odone = sel ? doneb : donea;
    wire opass = sel ? passb : passa;
    wire ofv   = sel ? fvb : fva;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic set_start(input bit s, input logic v);
        if (s) start_b = v;
        else start_a = v;
    endtask
    task automatic check_reset();
        check("rst_x_a", xa, 0);      check("rst_dq_a", dqa, 0);
        check("rst_busy_a", busya, 0); check("rst_done_a", donea, 0);
        check("rst_pass_a", passa, 0); check("rst_err_a", erra, 0);
        check("rst_fx_a", fxa, 0);    check("rst_fv_a", fva, 0);
        check("rst_x_b", xb, 0);      check("rst_busy_b", busyb, 0);
        check("rst_done_b", doneb, 0); check("rst_err_b", errb, 0);
        check("rst_fx_b", fxb, 0);    check("rst_fv_b", fvb, 0);
    endtask
    task automatic sweep(input bit s, input logic [15:0] m, input bit mid, input bit rel);
        int n, mx, cnt, fe;
        logic t, zprev;
        sel = s;
        n = s ? 16 : 8;
        mx = s ? 3 : 15;
        cnt = 0;
        fe = -1;
        zprev = 0;
        if (s) mask_b = m;
        else mask_a = m[7:0];
        @(negedge clk);
        if (rel) rst_n = 1;
        set_start(s, 1);
        @(negedge clk);
        set_start(s, 0);
        for (int i = 0; i < n; i++) begin
            t = s ? TBV[i[3:0]] : TA[i[2:0]];
            check("busy_run", obusy, 1);
            check("done_run", odone, 0);
            check("pass_run", opass, 0);
            check("x_run", ox, i);
            check("zt_run", ozt, t);
            check("err_run", oerr, cnt);
            check("fv_run", ofv, fe >= 0);
            if (i > 0) check("dq_run", odq, zprev);
            zprev = t ^ m[i];
            if (m[i]) begin
                if (cnt < mx) cnt++;
                if (fe < 0) fe = i;
            end
            set_start(s, mid && i == 5);
            @(negedge clk);
        end
        set_start(s, 0);
        check("done", odone, 1);
        check("busy_done", obusy, 0);
        check("pass", opass, cnt == 0);
        check("err_count", oerr, cnt);
        check("first_vld", ofv, fe >= 0);
        if (fe >= 0) check("first_x", ofx, fe);
        check("x_hold", ox, n - 1);
        check("dq_last", odq, zprev);
        check("zt_done", ozt, s ? TBV[15] : TA[7]);
    endtask
    task automatic abort_sweep(input logic [7:0] m);
        sel = 0;
        mask_a = m;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("abort_x", xa, 4);
        check("abort_busy", busya, 1);
        #2 rst_n = 0;
        #1 check_reset();
    endtask
    initial begin
        rst_n = 1;
        start_a = 0;
        start_b = 0;
        sel = 0;
        mask_a = 0;
        mask_b = 0;
        #3 rst_n = 0;
        #1 check_reset();
        @(negedge clk);
        rst_n = 1;
        sweep(0, 16'h0, 0, 0);
        sweep(0, {8'h0, TA}, 0, 0);
        sweep(1, TBV, 1, 0);
        sweep(1, 16'hffff, 0, 0);
        sweep(0, 16'h0, 0, 0);
        sweep(0, 16'h0, 0, 0);
        abort_sweep(8'($urandom));
        sweep(0, 16'($urandom), 0, 1);
        for (int k = 0; k < 8; k++)
            sweep(1'($urandom), 16'($urandom), 1'($urandom), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of function inputs (1..8).
REQ-002 SHALL have parameter TABLE, default 8'b01100001, width 2**N_IN, expected output; bit i = f(x=i).
REQ-003 SHALL have parameter ERR_W, default 4, error-counter width.
REQ-004 SHALL have port clock  input  1  single rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port dut_z  input  1  combinational output of the function under test, driven from x.
REQ-008 SHALL have port x  output  N_IN  registered stimulus vector.
REQ-009 SHALL have port z_t  output  1  expected value TABLE[x], combinational from x.
REQ-010 SHALL have port d_q  output  1  dut_z registered on every RUN cycle.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port pass  output  1  high in DONE when err_count == 0.
REQ-014 SHALL have port err_count  output  ERR_W  mismatch count, saturating.
REQ-015 SHALL have port first_err_x  output  N_IN  x value at first mismatch of the current sweep.
REQ-016 SHALL have port first_err_vld  output  1  first_err_x holds a valid capture.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: on start=1, SHALL go to RUN next edge, clearing x, err_count, first_err_vld and d_q.
REQ-019 RUN: each cycle SHALL compare dut_z with z_t for the current x; mismatch = dut_z != z_t.
REQ-020 RUN: on mismatch SHALL increment err_count by 1, holding at 2**ERR_W-1 (no wrap).
REQ-021 RUN: on the first mismatch of a sweep SHALL load first_err_x=x and set first_err_vld; later mismatches SHALL not change them.
REQ-022 RUN: SHALL increment x by 1 each cycle while x < 2**N_IN-1.
REQ-023 RUN: when x == 2**N_IN-1, SHALL evaluate that vector, then go to DONE; x SHALL hold at 2**N_IN-1, never wrap to 0.
REQ-024 A sweep SHALL occupy exactly 2**N_IN cycles with busy=1; done SHALL rise on the following edge.
REQ-025 start during RUN SHALL be ignored.
REQ-026 DONE: outputs SHALL hold; start=1 SHALL restart exactly as REQ-018, going directly to RUN.
REQ-027 pass SHALL be 0 outside DONE.
REQ-028 z_t SHALL be TABLE[x] at all times, including IDLE and DONE.

Reset
REQ-029 On rst_n=0, immediately and independent of clock: state=IDLE, x=0, d_q=0, err_count=0, first_err_x=0, first_err_vld=0; busy=done=pass=0.
REQ-030 Reset during RUN SHALL abort the sweep; a new sweep SHALL require start after rst_n rises.
REQ-031 start coincident with rst_n release edge: the first clock edge with rst_n=1 and start=1 SHALL begin the sweep.

Structure
REQ-032 FSM state encoding (IDLE, RUN, DONE) SHALL live in a shared package, tt_pkg.
REQ-033 The saturating error counter SHALL be a sub-module, sat_counter, parametrised by width, with clear and increment inputs.
REQ-034 No other sub-modules; the table lookup SHALL be an index into TABLE.

Verification
REQ-035 Defaults, dut_z = correct SOP of TABLE, pulse start -> busy 8 cycles, x 0..7, done=1, pass=1, err_count=0, first_err_vld=0.
REQ-036 Defaults, dut_z tied 0 -> err_count=3 (x=0,5,6), first_err_x=0, first_err_vld=1, pass=0.
REQ-037 ERR_W=2, dut_z = ~TABLE[x] -> 8 mismatches, err_count saturates at 3, first_err_x=0.
REQ-038 N_IN=4, TABLE=16'h8001, dut_z tied 0 -> 16-cycle sweep, err_count=2, first_err_x=0; start pulsed mid-sweep has no effect.
REQ-039 rst_n low at x=4 of RUN -> all outputs at reset values with no clock edge; start after release -> fresh sweep from x=0.
REQ-040 Two back-to-back sweeps, start in DONE -> second begins next edge with counters cleared, same results as first.
